aes_key_schedule: RTL and testbench
===================================

Name: aes_key_schedule

Overview:
- Upstream neighbour of decipher/cipher: expands a 128- or 256-bit AES cipher key into 11 or 15 round keys, one 32-bit word per clock, into an internal round-key store.
- Serves the round_key_no -> round_key read port with 1-cycle registered latency; replaces the key SRAM model used around decipher.

Parameters:
- NUM_KEYS, `Nr_256+1 (15), number of 128-bit round-key slots in the store.
- All widths come from aes.vh: `ROUND_KEY_BITS, `Nb, `Nr_128, `Nr_256.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-low (asserted when 0).
- en  in  1  start-expansion strobe; sampled only in IDLE.
- aes256  in  1  0 = AES-128 (Nk=4, Nr=10); 1 = AES-256 (Nk=8, Nr=14); sampled with en.
- key  in  256  cipher key; word w[j] = key[32j+31:32j], byte 0 in LSBs; AES-128 uses key[127:0].
- round_key_no  in  `Nb  read index from cipher/decipher.
- round_key  out  `ROUND_KEY_BITS  registered store[round_key_no].
- busy  out  1  high while expanding.
- en_o  out  1  one-cycle done pulse.

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; busy=0; en_o=0; round_key=0; all store slots=0; word counter, Rcon and window cleared. Reset mid-expansion aborts immediately; no done pulse.
- FSM IDLE -> EXPAND -> IDLE.
- IDLE, en==1 at edge E0:
  - latch aes256.
  - load key words w[0..Nk-1] into an 8-word sliding window and into store slots 0 (and 1 for AES-256).
  - set i=Nk, Rcon=8'h01, busy=1.
- EXPAND: one edge per word i = Nk .. 4*(Nr+1)-1 (40 edges for AES-128, 52 for AES-256), at E1..E40 / E1..E52:
  - temp = w[i-1].
  - i mod Nk==0: temp = SubWord(RotWord(temp)) ^ {24'h0, Rcon}, then Rcon = xtime(Rcon).
  - Nk==8 and i mod 8==4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp.
  - RotWord in this byte order is {t[7:0], t[31:8]}.
  - SubWord applies the codebase sbox to each of the 4 bytes.
  - Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
  - Write w[i] to store slot i/4, bits [32*(i%4)+31 : 32*(i%4)].
- Final word edge: state->IDLE, busy->0, en_o->1 for exactly one cycle. en_o is high in the cycle after E40 (AES-128) or E52 (AES-256).
- en while busy: ignored, no restart, key not re-sampled. en in the same cycle en_o is high is accepted (IDLE already).
- Read port, every cycle regardless of state: round_key <= (round_key_no < NUM_KEYS) ? store[round_key_no] : 0.
  - Latency: 1 clock.
  - Index 15 returns 0.
  - Read of a word written on the same edge returns the old value.
- New expansion overwrites slots progressively; slots above Nr keep stale contents from an earlier AES-256 run. Consumers never read slots above Nr.

Test Plan:
1. AES-128, key[127:0]=128'h0f0e0d0c0b0a09080706050403020100, en 1 cycle -> busy for 40 cycles, en_o single pulse after E40. Reads: slot 0 = 'h0f0e0d0c0b0a09080706050403020100, slot 1 = 'hfe76abd6f178a6dafa72afd2fd74aad6, slot 10 = 'hc5302b4d8ba707f3174a94e37f1d1113.
2. AES-256, key=256'h1f1e...0100 -> en_o after E52. Reads: slot 1 = 'h1f1e1d1c1b1a19181716151413121110, slot 2 = 'h9cc072a593ce7fa998c476a19fc273a5, slot 14 = 'h36de686d3cc21a37e97909bfcc79fc24.
3. Read timing: set round_key_no=3 then 7 on consecutive cycles after scenario 2 -> round_key shows 'hdeba4006c1a45d1adabe4402cda85116 then 'h39cf0754b49ebf27e7754752753ae23d, each one cycle later. round_key_no=15 -> 0.
4. Pulse en again at cycle 10 of an AES-128 expansion with a different key -> ignored; results identical to scenario 1, single en_o.
5. Assert reset (0) at cycle 20 of AES-256 expansion -> next cycle busy=0, en_o=0, round_key=0, all slots read 0. Restarting scenario 1 then passes.
6. Integration: key_schedule + decipher, ciphertext 'h5ac5b47080b7cdd830047b6ad8e0c469 (AES-128), and 'h8960494b9049fceabf456751cab7a28e (AES-256) -> plaintext 'hffeeddccbbaa99887766554433221100.

Source files
------------

// File: rtl/aes_key_schedule_if.sv
// Handshake and read-port bundle between the AES key schedule and its
// cipher/decipher consumers.
interface aes_key_schedule_if #(
  parameter int NB             = 4,
  parameter int ROUND_KEY_BITS = 128
);
  logic                      en;
  logic                      aes256;
  logic [255:0]              key;
  logic [NB-1:0]             round_key_no;
  logic [ROUND_KEY_BITS-1:0] round_key;
  logic                      busy;
  logic                      en_o;

  modport master (
    output en, aes256, key, round_key_no,
    input  round_key, busy, en_o
  );

  modport slave (
    input  en, aes256, key, round_key_no,
    output round_key, busy, en_o
  );
endinterface

// File: rtl/aes_key_schedule.sv
// AES-128/256 key expansion, one 32-bit word per clock, into a round-key
// store with a registered 1-cycle read port.
module aes_key_schedule #(
  parameter int NUM_KEYS = 15
) (
  input logic               clk,
  input logic               reset,
  aes_key_schedule_if.slave ks
);
  localparam int ROUND_KEY_BITS = 128;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_EXPAND = 1'b1} state_t;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the MSBs, so the bit offset of entry b is 8*(255-b).
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] off;
    off = {~b, 3'b000};
    return SBOX_TBL[off +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      r_aes256;
  logic [5:0]                r_i;
  logic [7:0]                r_rcon;
  logic [31:0]               r_win [0:7];
  logic [ROUND_KEY_BITS-1:0] r_store [0:NUM_KEYS-1];
  logic [ROUND_KEY_BITS-1:0] r_round_key;
  logic                      r_busy;
  logic                      r_en_o;

  logic                      w_load;
  logic                      w_step;
  logic                      w_last;
  logic                      w_rot;
  logic                      w_sub_only;
  logic                      w_busy_d;
  logic                      w_en_o_d;
  logic [31:0]               w_sub_in;
  logic [31:0]               w_sub;
  logic [31:0]               w_temp;
  logic [31:0]               w_new;

  // r_win[7] is w[i-1]; w[i-Nk] is r_win[4] for AES-128 and r_win[0] for AES-256.
  always_comb begin
    w_last     = (r_i == (r_aes256 ? 6'd59 : 6'd43));
    w_rot      = r_aes256 ? (r_i[2:0] == 3'd0) : (r_i[1:0] == 2'd0);
    w_sub_only = r_aes256 && (r_i[2:0] == 3'd4);
    w_sub_in   = w_rot ? {r_win[7][7:0], r_win[7][31:8]} : r_win[7];
    w_sub      = sub_word(w_sub_in);
    if (w_rot) begin
      w_temp = w_sub ^ {24'h000000, r_rcon};
    end else if (w_sub_only) begin
      w_temp = w_sub;
    end else begin
      w_temp = r_win[7];
    end
    w_new = (r_aes256 ? r_win[0] : r_win[4]) ^ w_temp;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   w_state_nxt = ks.en ? S_EXPAND : S_IDLE;
      S_EXPAND: w_state_nxt = w_last ? S_IDLE : S_EXPAND;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_load   = 1'b0;
    w_step   = 1'b0;
    w_en_o_d = 1'b0;
    case (r_state)
      S_IDLE:   w_load = ks.en;
      S_EXPAND: begin
        w_step   = 1'b1;
        w_en_o_d = w_last;
      end
      default:  w_load = 1'b0;
    endcase
    w_busy_d = (w_state_nxt == S_EXPAND);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_aes256 <= 1'b0;
      r_i      <= 6'd0;
      r_rcon   <= 8'h00;
      r_busy   <= 1'b0;
      r_en_o   <= 1'b0;
      for (int j = 0; j < 8; j++) r_win[j] <= 32'h0;
    end else begin
      r_busy <= w_busy_d;
      r_en_o <= w_en_o_d;
      if (w_load) begin
        r_aes256 <= ks.aes256;
        r_i      <= ks.aes256 ? 6'd8 : 6'd4;
        r_rcon   <= 8'h01;
        for (int j = 0; j < 4; j++) begin
          r_win[j]   <= ks.aes256 ? ks.key[32*j +: 32] : 32'h0;
          r_win[j+4] <= ks.aes256 ? ks.key[32*(j+4) +: 32] : ks.key[32*j +: 32];
        end
      end else if (w_step) begin
        for (int j = 0; j < 7; j++) r_win[j] <= r_win[j+1];
        r_win[7] <= w_new;
        r_i      <= r_i + 6'd1;
        if (w_rot) r_rcon <= xtime(r_rcon);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int s = 0; s < NUM_KEYS; s++) r_store[s] <= {ROUND_KEY_BITS{1'b0}};
    end else if (w_load) begin
      r_store[0] <= ks.key[127:0];
      if (ks.aes256) r_store[1] <= ks.key[255:128];
    end else if (w_step) begin
      r_store[r_i[5:2]][{r_i[1:0], 5'b00000} +: 32] <= w_new;
    end
  end

  // Out-of-range indices read as zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_round_key <= {ROUND_KEY_BITS{1'b0}};
    end else if (int'(ks.round_key_no) < NUM_KEYS) begin
      r_round_key <= r_store[ks.round_key_no];
    end else begin
      r_round_key <= {ROUND_KEY_BITS{1'b0}};
    end
  end

  assign ks.round_key = r_round_key;
  assign ks.busy      = r_busy;
  assign ks.en_o      = r_en_o;
endmodule

// File: tb/tb_aes_key_schedule.sv
// Randomized self-checking bench for aes_key_schedule against a FIPS-197 style
// word-array key expansion with an S-box derived from GF(2^8) inverses.
module tb_aes_key_schedule;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  logic [7:0]   sbox_tab [256];
  logic [127:0] exp_store [15];

  localparam logic [255:0] K128 = 256'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [255:0] K256 =
    256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;

  aes_key_schedule_if #(.NB(4), .ROUND_KEY_BITS(128)) ks_if ();

  aes_key_schedule #(.NUM_KEYS(15)) dut (
    .clk   (clk),
    .reset (reset),
    .ks    (ks_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int n = 0; n < 8; n++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
      sbox_tab[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] kk, input bit a256);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nw;
    nk = a256 ? 8 : 4;
    nw = a256 ? 60 : 44;
    rc = 8'h01;
    for (int j = 0; j < nk; j++) w[j] = kk[32*j +: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[7:0], t[31:8]}) ^ {24'h000000, rc};
        rc = xt(rc);
      end else if (nk == 8 && i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int s = 0; s < nw / 4; s++)
      exp_store[s] = {w[4*s+3], w[4*s+2], w[4*s+1], w[4*s]};
  endtask

  task automatic read_chk(input string tag, input int s, input logic [127:0] exp);
    ks_if.round_key_no = 4'(s);
    @(posedge clk); #1;
    check_eq(tag, ks_if.round_key, exp);
  endtask

  task automatic read_model(input string tag, input int s);
    read_chk(tag, s, (s < 15) ? exp_store[s] : 128'h0);
  endtask

  // ign_at: cycle for a stray en pulse; abort_at: cycle to assert reset (0 = none).
  task automatic run_exp(input string tag, input logic [255:0] kk, input bit a256,
                         input int ign_at, input int abort_at);
    int busy_cnt, done_at, exp_cyc;
    exp_cyc = a256 ? 52 : 40;
    @(posedge clk); #1;
    ks_if.en = 1'b1; ks_if.aes256 = a256; ks_if.key = kk;
    @(posedge clk); #1;
    ks_if.en = 1'b0;
    check_eq({tag, "_busy_start"}, ks_if.busy, 1'b1);
    busy_cnt = 1;
    done_at  = 0;
    for (int c = 1; c <= 100; c++) begin
      if (c == ign_at) begin
        ks_if.en = 1'b1; ks_if.key = ~kk; ks_if.aes256 = ~a256;
      end else begin
        ks_if.en = 1'b0;
      end
      if (c == abort_at) reset = 1'b0;
      @(posedge clk); #1;
      if (c == abort_at) begin
        check_eq({tag, "_abort_busy"}, ks_if.busy, 1'b0);
        check_eq({tag, "_abort_en_o"}, ks_if.en_o, 1'b0);
        check_eq({tag, "_abort_rk"}, ks_if.round_key, 128'h0);
        reset = 1'b1;
        for (int s = 0; s < 15; s++) exp_store[s] = 128'h0;
        break;
      end
      if (ks_if.en_o) begin
        done_at = c;
        break;
      end
      if (ks_if.busy) busy_cnt++;
    end
    ks_if.en = 1'b0;
    if (abort_at != 0) begin
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        check_eq({tag, "_post_abort_en_o"}, ks_if.en_o, 1'b0);
      end
    end else begin
      check_eq({tag, "_done_cycle"}, 128'(done_at), 128'(exp_cyc));
      check_eq({tag, "_busy_cycles"}, 128'(busy_cnt), 128'(exp_cyc));
      check_eq({tag, "_busy_at_done"}, ks_if.busy, 1'b0);
      @(posedge clk); #1;
      check_eq({tag, "_en_o_single"}, ks_if.en_o, 1'b0);
      model_expand(kk, a256);
    end
  endtask

  initial begin
    logic [255:0] rkey;
    bit           rmode;
    n_checks = 0;
    n_errors = 0;
    build_sbox();
    for (int s = 0; s < 15; s++) exp_store[s] = 128'h0;
    ks_if.en = 1'b0; ks_if.aes256 = 1'b0; ks_if.key = 256'h0; ks_if.round_key_no = 4'd0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_busy", ks_if.busy, 1'b0);
    check_eq("reset_en_o", ks_if.en_o, 1'b0);
    check_eq("reset_rk", ks_if.round_key, 128'h0);
    reset = 1'b1;

    run_exp("s1", K128, 1'b0, 0, 0);
    read_chk("s1_slot0", 0, 128'h0f0e0d0c0b0a09080706050403020100);
    read_chk("s1_slot1", 1, 128'hfe76abd6f178a6dafa72afd2fd74aad6);
    read_chk("s1_slot10", 10, 128'hc5302b4d8ba707f3174a94e37f1d1113);

    run_exp("s2", K256, 1'b1, 0, 0);
    read_chk("s2_slot1", 1, 128'h1f1e1d1c1b1a19181716151413121110);
    read_chk("s2_slot2", 2, 128'h9cc072a593ce7fa998c476a19fc273a5);
    read_chk("s2_slot14", 14, 128'h36de686d3cc21a37e97909bfcc79fc24);
    read_chk("s3_slot3", 3, 128'hdeba4006c1a45d1adabe4402cda85116);
    read_chk("s3_slot7", 7, 128'h39cf0754b49ebf27e7754752753ae23d);
    read_chk("s3_slot15", 15, 128'h0);

    run_exp("s4", K128, 1'b0, 10, 0);
    read_chk("s4_slot1", 1, 128'hfe76abd6f178a6dafa72afd2fd74aad6);
    read_chk("s4_slot10", 10, 128'hc5302b4d8ba707f3174a94e37f1d1113);
    for (int s = 0; s < 15; s++) read_model("s4_model", s);

    run_exp("s5", K256, 1'b1, 0, 20);
    for (int s = 0; s < 16; s++) read_chk("s5_cleared", s, 128'h0);
    run_exp("s5_rerun", K128, 1'b0, 0, 0);
    read_chk("s5_slot10", 10, 128'hc5302b4d8ba707f3174a94e37f1d1113);
    read_chk("s5_slot11_zero", 11, 128'h0);

    for (int it = 0; it < 8; it++) begin
      for (int j = 0; j < 8; j++) rkey[32*j +: 32] = $urandom;
      rmode = 1'($urandom_range(0, 1));
      run_exp("rand", rkey, rmode, 0, 0);
      for (int r = 0; r < 6; r++) read_model("rand_slot", $urandom_range(0, 15));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
